// File: rtl/traffic_pkg.sv
// Shared definitions for the junction safety monitor: lamp aspect encodings,
// latched fault codes, the monitor FSM state type and a fault priority helper.
package traffic_pkg;

  // Aspect encoding {red, yellow, green}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  // Fault causes; a lower value has higher priority
  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENCODING  = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SKIP_YEL  = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_ILL_TRANS = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Merge two fault codes keeping the higher-priority (lowest non-zero) one
  function automatic logic [2:0] code_pick(input logic [2:0] a, input logic [2:0] b);
    if (a == FC_NONE) return b;
    if (b == FC_NONE) return a;
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/aspect_tracker.sv
// Per-direction aspect checker: remembers the previous aspect and the length
// of the current yellow run, and flags encoding/sequencing faults.
// Ports:
//   clk, rst        junction clock, async active-low reset
//   i_light [2:0]   current controller aspect for this direction
//   o_code_c [2:0]  combinational fault code for this direction (0 = none)
module aspect_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned YEL_MIN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_light,
  output logic [2:0] o_code_c
);

  localparam int unsigned CW = $clog2(YEL_MIN + 1);

  logic [2:0]    r_prev;
  logic [CW-1:0] r_ycnt;
  logic          w_onehot;

  // Previous aspect and yellow run length; the run counts the current Y sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= LT_RED;
      r_ycnt <= CW'(YEL_MIN);
    end else begin
      r_prev <= i_light;
      if (i_light == LT_YEL) begin
        if (r_prev != LT_YEL) begin
          r_ycnt <= CW'(1);
        end else if (r_ycnt != CW'(YEL_MIN)) begin
          r_ycnt <= r_ycnt + CW'(1);
        end
      end
    end
  end

  assign w_onehot = (i_light == LT_RED) || (i_light == LT_YEL) || (i_light == LT_GRN);

  // Local checks in priority order
  always_comb begin
    o_code_c = FC_NONE;
    if (!w_onehot) begin
      o_code_c = FC_ENCODING;
    end else if ((r_prev == LT_GRN) && (i_light == LT_RED)) begin
      o_code_c = FC_SKIP_YEL;
    end else if ((r_prev == LT_YEL) && (i_light == LT_RED) && (r_ycnt < CW'(YEL_MIN))) begin
      o_code_c = FC_SHORT_YEL;
    end else if (((r_prev == LT_RED) && (i_light == LT_YEL)) ||
                 ((r_prev == LT_YEL) && (i_light == LT_GRN))) begin
      o_code_c = FC_ILL_TRANS;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Passes legal aspects through with one cycle of latency; on the first
// violation latches a fault code and flashes all lamps red until cleared.
// Ports:
//   clk, rst                      junction clock, async active-low reset
//   light_M1/M2/MT/S [2:0]        controller aspects
//   fault_clr                     request to leave FAULT (needs all inputs red)
//   lamp_M1/M2/MT/S [2:0]         registered lamp drive
//   fault                         high while in FAULT
//   fault_code [2:0]              latched fault cause
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned YEL_MIN    = 3,
  parameter int unsigned STARTUP    = 4,
  parameter int unsigned FLASH_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       fault_clr,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned NDIR = 4;
  localparam int unsigned SW   = $clog2(STARTUP + 1);
  localparam int unsigned FW   = $clog2(2 * FLASH_HALF + 1);

  // Direction index: 0 M1, 1 M2, 2 MT, 3 S
  logic [2:0]    w_light    [NDIR];
  logic [2:0]    w_dir_code [NDIR];
  logic [NDIR-1:0] w_nonred;
  logic          w_conflict;
  logic          w_all_red;
  logic [2:0]    w_viol;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_start, w_start_nxt;
  logic [FW-1:0] r_flash, w_flash_nxt;
  logic          r_fault, w_fault_nxt;
  logic [2:0]    r_code,  w_code_nxt;
  logic [2:0]    r_lamp     [NDIR];
  logic [2:0]    w_lamp_nxt [NDIR];

  assign w_light[0] = light_M1;
  assign w_light[1] = light_M2;
  assign w_light[2] = light_MT;
  assign w_light[3] = light_S;

  for (genvar g = 0; g < NDIR; g++) begin : g_trk
    aspect_tracker #(
      .YEL_MIN (YEL_MIN)
    ) u_trk (
      .clk      (clk),
      .rst      (rst),
      .i_light  (w_light[g]),
      .o_code_c (w_dir_code[g])
    );
    assign w_nonred[g] = (w_light[g] != LT_RED);
  end

  // S conflicts with every main direction; MT conflicts with M2; M1+M2 is legal
  assign w_conflict = (w_nonred[3] && (w_nonred[0] || w_nonred[1] || w_nonred[2])) ||
                      (w_nonred[2] && w_nonred[1]);
  assign w_all_red  = ~|w_nonred;

  // Priority select across conflict and all per-direction codes
  always_comb begin
    w_viol = w_conflict ? FC_CONFLICT : FC_NONE;
    for (int i = 0; i < int'(NDIR); i++) begin
      w_viol = code_pick(w_viol, w_dir_code[i]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_start <= '0;
      r_flash <= '0;
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      for (int i = 0; i < int'(NDIR); i++) begin
        r_lamp[i] <= LT_RED;
      end
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_nxt;
      r_flash <= w_flash_nxt;
      r_fault <= w_fault_nxt;
      r_code  <= w_code_nxt;
      for (int i = 0; i < int'(NDIR); i++) begin
        r_lamp[i] <= w_lamp_nxt[i];
      end
    end
  end

  // Next state and registered output values
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = r_start;
    w_flash_nxt = r_flash;
    w_fault_nxt = r_fault;
    w_code_nxt  = r_code;
    for (int i = 0; i < int'(NDIR); i++) begin
      w_lamp_nxt[i] = r_lamp[i];
    end

    unique case (r_state)
      ST_INIT: begin
        for (int i = 0; i < int'(NDIR); i++) begin
          w_lamp_nxt[i] = LT_RED;
        end
        if (r_start == SW'(STARTUP - 1)) begin
          w_state_nxt = ST_RUN;
          w_start_nxt = '0;
        end else begin
          w_start_nxt = r_start + SW'(1);
        end
      end

      ST_RUN: begin
        if (w_viol != FC_NONE) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = 1'b1;
          w_code_nxt  = w_viol;
          w_flash_nxt = '0;
          for (int i = 0; i < int'(NDIR); i++) begin
            w_lamp_nxt[i] = LT_RED;
          end
        end else begin
          for (int i = 0; i < int'(NDIR); i++) begin
            w_lamp_nxt[i] = w_light[i];
          end
        end
      end

      ST_FAULT: begin
        if (fault_clr && w_all_red) begin
          w_state_nxt = ST_INIT;
          w_fault_nxt = 1'b0;
          w_code_nxt  = FC_NONE;
          w_start_nxt = '0;
          w_flash_nxt = '0;
          for (int i = 0; i < int'(NDIR); i++) begin
            w_lamp_nxt[i] = LT_RED;
          end
        end else begin
          // Flash counter spans one full on/off period; the first half is "on"
          if (r_flash == FW'(2 * FLASH_HALF - 1)) begin
            w_flash_nxt = '0;
          end else begin
            w_flash_nxt = r_flash + FW'(1);
          end
          for (int i = 0; i < int'(NDIR); i++) begin
            w_lamp_nxt[i] = (w_flash_nxt < FW'(FLASH_HALF)) ? LT_RED : LT_OFF;
          end
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
        w_start_nxt = '0;
      end
    endcase
  end

  assign lamp_M1    = r_lamp[0];
  assign lamp_M2    = r_lamp[1];
  assign lamp_MT    = r_lamp[2];
  assign lamp_S     = r_lamp[3];
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios followed by random
// traffic, each cycle compared against a rule-level reference model.
module tb_traffic_conflict_monitor;

  localparam int YM = 3;
  localparam int SU = 4;
  localparam int FH = 1;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
  logic       fault_clr = 1'b0;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [2:0] fault_code;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_mode;
  int         m_init_edges;
  int         m_age;
  logic [2:0] m_prev  [4];
  int         m_yrun  [4];
  logic [2:0] m_lamps [4];
  logic [2:0] m_code;

  // Conflicting direction pairs (0 M1, 1 M2, 2 MT, 3 S)
  int pair_a [4] = '{3, 3, 3, 2};
  int pair_b [4] = '{0, 1, 2, 1};

  traffic_conflict_monitor #(
    .YEL_MIN    (YM),
    .STARTUP    (SU),
    .FLASH_HALF (FH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .light_M1   (light_M1),
    .light_M2   (light_M2),
    .light_MT   (light_MT),
    .light_S    (light_S),
    .fault_clr  (fault_clr),
    .lamp_M1    (lamp_M1),
    .lamp_M2    (lamp_M2),
    .lamp_MT    (lamp_MT),
    .lamp_S     (lamp_S),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("lamp_M1", lamp_M1, m_lamps[0]);
    chk("lamp_M2", lamp_M2, m_lamps[1]);
    chk("lamp_MT", lamp_MT, m_lamps[2]);
    chk("lamp_S", lamp_S, m_lamps[3]);
    chk("fault", {2'b00, fault}, (m_mode == M_FAULT) ? 3'd1 : 3'd0);
    chk("fault_code", fault_code, m_code);
  endtask

  task automatic model_reset();
    m_mode = M_INIT;
    m_init_edges = 0;
    m_age = 0;
    m_code = 3'd0;
    for (int d = 0; d < 4; d++) begin
      m_prev[d]  = R;
      m_yrun[d]  = YM;
      m_lamps[d] = R;
    end
  endtask

  function automatic bit legal(input logic [2:0] a);
    return (a == R) || (a == Y) || (a == G);
  endfunction

  function automatic int pick(input int cur, input int c);
    return (cur == 0 || c < cur) ? c : cur;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic [2:0] a0, input logic [2:0] a1,
                      input logic [2:0] a2, input logic [2:0] a3, input logic clr);
    logic [2:0] in [4];
    int v;
    bit all_red;
    in[0] = a0; in[1] = a1; in[2] = a2; in[3] = a3;
    light_M1 = a0; light_M2 = a1; light_MT = a2; light_S = a3;
    fault_clr = clr;

    v = 0;
    all_red = 1'b1;
    for (int d = 0; d < 4; d++) if (in[d] != R) all_red = 1'b0;
    if (m_mode == M_RUN) begin
      for (int d = 0; d < 4; d++) if (!legal(in[d])) v = pick(v, 1);
      for (int p = 0; p < 4; p++)
        if (in[pair_a[p]] != R && in[pair_b[p]] != R) v = pick(v, 2);
      for (int d = 0; d < 4; d++) begin
        if (m_prev[d] == G && in[d] == R) v = pick(v, 3);
        if (m_prev[d] == Y && in[d] == R && m_yrun[d] < YM) v = pick(v, 4);
        if ((m_prev[d] == R && in[d] == Y) || (m_prev[d] == Y && in[d] == G)) v = pick(v, 5);
      end
    end

    for (int d = 0; d < 4; d++) begin
      if (in[d] == Y) m_yrun[d] = (m_prev[d] == Y) ? m_yrun[d] + 1 : 1;
      m_prev[d] = in[d];
    end

    case (m_mode)
      M_INIT: begin
        m_init_edges++;
        for (int d = 0; d < 4; d++) m_lamps[d] = R;
        if (m_init_edges == SU) m_mode = M_RUN;
      end
      M_RUN: begin
        if (v != 0) begin
          m_mode = M_FAULT;
          m_code = 3'(v);
          m_age = 0;
          for (int d = 0; d < 4; d++) m_lamps[d] = R;
        end else begin
          for (int d = 0; d < 4; d++) m_lamps[d] = in[d];
        end
      end
      default: begin
        if (clr && all_red) begin
          m_mode = M_INIT;
          m_init_edges = 0;
          m_code = 3'd0;
          for (int d = 0; d < 4; d++) m_lamps[d] = R;
        end else begin
          m_age++;
          for (int d = 0; d < 4; d++) m_lamps[d] = (((m_age / FH) % 2) == 0) ? R : OFF;
        end
      end
    endcase

    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic startup_red();
    for (int k = 0; k < SU; k++) step(R, R, R, R, 1'b0);
  endtask

  task automatic clear_fault();
    step(R, R, R, R, 1'b1);
    chk("clear_fault", {2'b00, fault}, 3'd0);
    chk("clear_code", fault_code, 3'd0);
  endtask

  function automatic logic [2:0] rnd_next(input logic [2:0] p);
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 11) return p;
    if (r < 15) begin
      case (p)
        G:       return Y;
        Y:       return R;
        R:       return G;
        default: return R;
      endcase
    end
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    // Reset with M1/M2 green, others red
    light_M1 = G; light_M2 = G;
    #2 rst = 1'b0;
    #1;
    check_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b1;

    // Startup: four red cycles then pass-through
    for (int k = 0; k < SU; k++) begin
      step(G, G, R, R, 1'b0);
      chk("startup_red", lamp_M1, R);
    end
    step(G, G, R, R, 1'b0);
    chk("first_pass", lamp_M1, G);

    // Legal M1 sequence G,G,Y,Y,Y,R
    step(G, G, R, R, 1'b0);
    step(Y, G, R, R, 1'b0);
    step(Y, G, R, R, 1'b0);
    step(Y, G, R, R, 1'b0);
    step(R, G, R, R, 1'b0);
    chk("legal_seq_nofault", {2'b00, fault}, 3'd0);
    chk("legal_seq_lamp", lamp_M1, R);

    // Short yellow G,Y,Y,R
    step(G, G, R, R, 1'b0);
    step(Y, G, R, R, 1'b0);
    step(Y, G, R, R, 1'b0);
    step(R, G, R, R, 1'b0);
    chk("short_yel_code", fault_code, 3'd4);
    chk("short_yel_lamp", lamp_M2, R);
    step(G, G, R, R, 1'b0);
    chk("flash_off", lamp_M2, OFF);
    step(G, G, R, R, 1'b0);
    chk("flash_on", lamp_M2, R);

    clear_fault();
    startup_red();

    // Encoding fault outranks conflict
    step(R, 3'b011, G, G, 1'b0);
    chk("enc_priority", fault_code, 3'd1);

    // Clear ignored while S is green, accepted once all red
    step(R, R, R, G, 1'b1);
    chk("clr_ignored", {2'b00, fault}, 3'd1);
    chk("clr_ignored_code", fault_code, 3'd1);
    clear_fault();
    startup_red();
    step(G, R, R, R, 1'b0);
    chk("pass_after_clear", lamp_M1, G);

    // Skipped yellow, then reset in the dark half of the flash
    step(R, R, R, R, 1'b0);
    chk("skip_yel_code", fault_code, 3'd3);
    step(R, R, R, R, 1'b0);
    chk("flash_dark", lamp_S, OFF);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("reset_mid_flash", lamp_MT, R);
    @(posedge clk);
    #1;
    rst = 1'b1;
    startup_red();

    // Illegal R->Y
    step(R, R, Y, R, 1'b0);
    chk("ill_trans_code", fault_code, 3'd5);
    clear_fault();
    startup_red();

    // Conflict S with M1
    step(G, R, R, G, 1'b0);
    chk("conflict_code", fault_code, 3'd2);
    clear_fault();
    startup_red();

    // Random traffic with recovery
    for (int n = 0; n < 600; n++) begin
      if (m_mode == M_FAULT && $urandom_range(0, 2) == 0) begin
        step(R, R, R, R, 1'($urandom_range(0, 3) != 0));
      end else begin
        step(rnd_next(m_prev[0]), rnd_next(m_prev[1]), rnd_next(m_prev[2]),
             rnd_next(m_prev[3]), 1'($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety monitor sitting directly downstream of the `trafficlight` controller, between its four 3-bit aspect outputs and the lamp drivers. It passes legal aspects through with one cycle of latency. It checks every sampled aspect for illegal encodings, conflicting greens and illegal sequencing. On the first violation it latches a fault code and forces all lamps to flashing red until the fault is explicitly cleared.

## Interface
Parameters:
- `YEL_MIN`, 3: minimum consecutive yellow cycles before red (1 cycle = 1 s at the 1 Hz junction clock).
- `STARTUP`, 4: all-red cycles after reset or fault clear before monitoring starts.
- `FLASH_HALF`, 1: cycles per on/off half-period of fault flashing.

Ports:
- `clk`  in  1: junction clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `light_M1`, `light_M2`, `light_MT`, `light_S`  in  3 each: controller aspects. Encoding {red, yellow, green}: 3'b100 R, 3'b010 Y, 3'b001 G.
- `lamp_M1`, `lamp_M2`, `lamp_MT`, `lamp_S`  out  3 each: registered lamp drive, same encoding.
- `fault_clr`  in  1: single-cycle request to clear a latched fault.
- `fault`  out  1: high while in FAULT.
- `fault_code`  out  3: latched cause. 0 none, 1 illegal encoding, 2 conflict, 3 skipped yellow, 4 short yellow, 5 illegal transition.

## Operation
- FSM states: INIT, RUN, FAULT.
- Reset (rst=0, async) forces INIT:
  - all lamps 3'b100;
  - `fault`=0, `fault_code`=0;
  - startup counter=0, flash counter=0;
  - yellow counters saturated at YEL_MIN.
- INIT:
  - lamps held all red; inputs not checked.
  - Per-direction previous-aspect registers load the inputs every cycle.
  - After STARTUP cycles, go to RUN.
- RUN: inputs checked combinationally each cycle. With no violation, lamps <= inputs. Checks:
  - Code 1: any direction not exactly one-hot.
  - Code 2: S non-red while any of M1/M2/MT is non-red; or MT non-red while M2 is non-red. M1 with M2 is legal.
  - Code 3: G -> R on any direction.
  - Code 4: Y -> R with yellow counter < YEL_MIN.
  - Code 5: R -> Y or Y -> G.
- Simultaneous violations: lowest code wins; all directions are evaluated in parallel.
- On any violation: next state FAULT, `fault_code` latched, `fault`=1. The offending aspect never reaches the lamps.
- Yellow counter, one per direction:
  - cleared on the cycle entering Y;
  - increments while Y persists (the first Y cycle counts as 1);
  - saturates at YEL_MIN;
  - width clog2(YEL_MIN+1).
- FAULT:
  - All lamps = 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating. The flash phase restarts at "on" on every entry to FAULT.
  - Inputs are ignored; `fault_code` is stable.
- Fault clear: a `fault_clr` high while all four inputs are 3'b100 causes the following:
  - next state INIT;
  - `fault`=0 and `fault_code`=0 on the same edge;
  - startup sequence repeats.
  - A `fault_clr` with any input non-red is ignored (no memory of the request).
- `fault_clr` in INIT or RUN has no effect.

## Timing
- Pass-through latency: exactly 1 cycle (input sampled at edge t appears on lamps after edge t).
- Violation sampled at edge t: at edge t, `fault`=1, code valid, lamps red.
- After reset release, lamps mirror inputs from edge STARTUP+1 onward.
- Reset asserted mid-FAULT or mid-yellow: immediate all red, all state discarded.

## Structure
- Shared package `traffic_pkg` holds:
  - aspect constants LT_RED, LT_YEL, LT_GRN;
  - fault code constants;
  - the FSM state enum.
- Sub-module `aspect_tracker`, instantiated 4x. It contains:
  - previous-aspect register;
  - yellow counter;
  - one-hot and transition checks (codes 1, 3, 4, 5) for one direction, output as a per-direction code.
- The top level holds the conflict matrix, priority select, FSM, startup and flash counters.

## Test plan
- Reset release with all inputs green on M1/M2 and red elsewhere -> lamps stay 3'b100 for 4 cycles, then mirror inputs; `fault`=0.
- M1 sequence G,G,Y,Y,Y,R -> passes through 1 cycle late; no fault.
- M1 sequence G,Y,Y,R (2 yellows) -> `fault`=1, code 4 at the R sample; lamps flash 100/000 every cycle.
- S=G while MT=G, plus M2=3'b011 on the same cycle -> code 1 (priority over 2).
- In FAULT:
  - `fault_clr` with S=G -> ignored;
  - then all inputs red plus `fault_clr` -> next edge `fault`=0, code 0, 4 red cycles, then pass-through.
- Assert `rst` mid-flash (lamps 000) -> lamps 3'b100 immediately, code 0.
